// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory and decode handshake bundle
//
// Purpose: groups the fetch unit's instruction-memory bus and its decode-side
//          valid/ready handshake into one interface.
// Signals:
//   imem_rd        fetch -> mem     read strobe
//   imem_wn        fetch -> mem     write enable (never asserted by fetch)
//   imem_address   fetch -> mem     word address (the current pc)
//   imem_read_data mem   -> fetch   combinational read data for imem_address
//   if_valid       fetch -> decode  head entry holds an instruction
//   if_ready       decode -> fetch  decode takes the head this cycle
//   if_instr       fetch -> decode  head instruction
//   if_pc          fetch -> decode  pc of the head instruction
// Modports: master = fetch unit side, slave = memory/decode side.

interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              imem_rd;
  logic              imem_wn;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_read_data;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output imem_rd, imem_wn, imem_address, if_valid, if_instr, if_pc,
    input  imem_read_data, if_ready
  );

  modport slave (
    input  imem_rd, imem_wn, imem_address, if_valid, if_instr, if_pc,
    output imem_read_data, if_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage with prefetch FIFO and redirect
//
// Purpose: holds the pc, reads one word per cycle from a combinational-read
//          instruction memory, buffers {instr, pc} pairs in a small FIFO and
//          hands them to decode over a valid/ready handshake. A redirect
//          flushes the FIFO and restarts fetch at the target.
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   fetch_en        1 = fetch allowed, 0 = hold pc and stop pushing
//   redirect_valid  load redirect_pc and flush the FIFO (highest priority)
//   redirect_pc     redirect target word address
//   fetch_count     pushes since reset, wraps
//   bus             master side of instruction_fetch_unit_if (memory + decode)

module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic [31:0]               fetch_count,
  instruction_fetch_unit_if.master  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] epc_q   [DEPTH];

  logic push;
  logic pop;

  // Push depends only on the pre-edge count, so a full FIFO does not refill
  // in the same cycle it is popped; this keeps if_ready off the memory path.
  assign push = fetch_en & ~redirect_valid & (count_q < CNT_W'(DEPTH));
  assign pop  = (count_q != '0) & bus.if_ready & ~redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d          = pc_q + ADDR_W'(1);
        wr_ptr_d      = wr_ptr_q + PTR_W'(1);
        fetch_count_d = fetch_count_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fetch_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fetch_count_q <= fetch_count_d;
      if (push) begin
        instr_q[wr_ptr_q] <= bus.imem_read_data;
        epc_q[wr_ptr_q]   <= pc_q;
      end
    end
  end

  assign bus.imem_rd      = 1'b1;
  assign bus.imem_wn      = 1'b0;
  assign bus.imem_address = pc_q;
  assign bus.if_valid     = (count_q != '0);
  assign bus.if_instr     = instr_q[rd_ptr_q];
  assign bus.if_pc        = epc_q[rd_ptr_q];
  assign fetch_count      = fetch_count_q;

endmodule
